sprite_engine: RTL and testbench
================================

Name: sprite_engine

Overview:
- Multi-sprite overlay generator for the VGA path.
- Draws NUM_SPRITES independent monochrome bitmap sprites over the pixel stream from vga_timing.
- Per-sprite position, velocity, colour, flip and enable live in a CPU-writable register file on the 6502 bus.
- Moves auto-move sprites once per frame with edge bounce, resolves priority, and latches sprite-sprite collisions.

Parameters:
- NUM_SPRITES, 4, number of sprites (1..8).
- SPRITE_W, 8, sprite width in pixels (1..8).
- SPRITE_H, 8, sprite height in rows (1..8).
- COORD_W, 11, pixel coordinate width.
- H_ACTIVE, 800, visible width.
- V_ACTIVE, 600, visible height.

Ports:
- CLK_PIXEL  in  1  pixel clock, sole clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- PIXEL_X  in  COORD_W  current pixel column.
- PIXEL_Y  in  COORD_W  current pixel row.
- ON_SCREEN  in  1  pixel is in the visible area.
- FRAME_START  in  1  one-cycle pulse at the start of vertical blank.
- REG_WE  in  1  register write strobe, one cycle.
- REG_ADDR  in  8  register address.
- REG_DATA  in  8  write data.
- VGA_RED  out  1  red output, registered.
- VGA_GREEN  out  1  green output, registered.
- VGA_BLUE  out  1  blue output, registered.
- COLLISION  out  1  sticky flag: two sprites overlapped.

Behaviour:
- Reset (async assert, sync release):
  - All registers and bitmaps are 0; all sprites disabled.
  - VGA_RED, VGA_GREEN, VGA_BLUE and COLLISION are 0.
- Register map, per sprite s, base = s*16:
  - +0: X[7:0]; +1: X[COORD_W-1:8].
  - +2: Y[7:0]; +3: Y[COORD_W-1:8].
  - +4: DX, signed 8-bit; +5: DY, signed 8-bit.
  - +6: CTRL. bit0 enable, bit1 flip_h, bit2 auto_move, bits[5:3] colour {R,G,B}.
  - +8..+8+SPRITE_H-1: bitmap rows. bit 7 is the leftmost pixel; only the upper SPRITE_W bits are used.
- Global address 0xF0: any write clears COLLISION.
- Writes to unmapped addresses, or to sprites >= NUM_SPRITES, are ignored.
- Writes take effect on the next clock.
- Hit test, per sprite, combinational:
  - in-box when X <= PIXEL_X < X+SPRITE_W and Y <= PIXEL_Y < Y+SPRITE_H, using COORD_W+1-bit compares (no wrap).
  - col = PIXEL_X-X; row = PIXEL_Y-Y.
  - Bit index = 7-col, or 7-(SPRITE_W-1-col) when flip_h is set.
  - opaque = enable && in-box && bitmap[row][bit].
- Output stage:
  - Output pipeline register, latency exactly 1 cycle from PIXEL_X/PIXEL_Y/ON_SCREEN.
  - The integrator delays HSYNC and VSYNC by 1 cycle to match.
  - Lowest-index opaque sprite wins; its colour drives the RGB outputs.
  - RGB is 0 when no sprite is opaque or ON_SCREEN is 0.
- Collision:
  - Sets when ON_SCREEN and two or more sprites are opaque; visible on the output 1 cycle later.
  - Holds until a 0xF0 write; if set and clear occur in the same cycle, set wins.
- Motion, on FRAME_START, for each sprite with enable && auto_move:
  - nx = X + sext(DX), computed signed at COORD_W+1 bits.
  - If nx < 0: X = 0 and DX = -DX.
  - If nx > H_ACTIVE-SPRITE_W: X = H_ACTIVE-SPRITE_W and DX = -DX.
  - Otherwise X = nx.
  - Y axis uses the same rules with V_ACTIVE and SPRITE_H.
  - DX = -128 negates to +127 (saturating).
- Simultaneous REG_WE and FRAME_START on the same register: the CPU write wins. Other fields of that sprite still update.
- Reset mid-frame: outputs drop to 0 immediately, since the output registers are asynchronous-reset.

Decomposition:
- Package sprite_pkg holds:
  - register offsets (OFS_XLO..OFS_BMP, ADDR_COLL_CLR = 8'hF0);
  - CTRL bit positions;
  - the per-sprite state struct (x, y, dx, dy, ctrl, bitmap).
- One sub-module sprite_unit, instantiated NUM_SPRITES times, holds:
  - that sprite's registers and write decode;
  - the frame-step motion/bounce logic;
  - the hit test, with outputs opaque and colour.
- The top level holds the priority encoder, collision counting and the output register.

Test Plan:
1. Reset, then sweep a full frame -> RGB = 0 and COLLISION = 0 throughout; all registers read back 0 via hierarchy.
2. Sprite 0 at X=20, Y=40, row0 = 0x80, colour red, enabled; drive PIXEL_X=20, PIXEL_Y=40 -> VGA_RED=1 one cycle later. Same with PIXEL_X=21 -> 0. Set flip_h -> pixel (27,40) lit and (20,40) dark.
3. Sprite 0 red and sprite 1 blue, both full 0xFF at the same X/Y -> output red only, COLLISION=1. Write 0xF0 -> COLLISION=0 until the next overlap.
4. X=790, DX=+5, auto_move, SPRITE_W=8 -> after FRAME_START X=792 and DX=-5. Next frame X=787.
5. Y=2, DY=-3 -> after FRAME_START Y=0 and DY=+3. DX=-128 at a bounce -> DX=+127.
6. Write X lo on the same cycle as FRAME_START with DY nonzero -> X equals the written value and Y still steps. Assert RESET_N low mid-line -> RGB drops without waiting for a clock edge.

Source files
------------

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
//   Shared definitions for the sprite overlay engine: register map offsets
//   within a sprite's 16-byte window, CTRL bit positions, the per-sprite state
//   record and the saturating velocity negate used by the edge bounce.
//   State fields are sized for the largest supported configuration
//   (16-bit coordinates, 8 rows of 8 pixels); narrower builds keep the unused
//   upper bits at zero.
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam int COORD_W_MAX = 16;
  localparam int ROWS_MAX    = 8;

  // Offsets inside a sprite's window (address bits [3:0]).
  localparam logic [3:0] OFS_XLO  = 4'h0;
  localparam logic [3:0] OFS_XHI  = 4'h1;
  localparam logic [3:0] OFS_YLO  = 4'h2;
  localparam logic [3:0] OFS_YHI  = 4'h3;
  localparam logic [3:0] OFS_DX   = 4'h4;
  localparam logic [3:0] OFS_DY   = 4'h5;
  localparam logic [3:0] OFS_CTRL = 4'h6;
  localparam logic [3:0] OFS_BMP  = 4'h8;

  localparam logic [7:0] ADDR_COLL_CLR = 8'hF0;

  // CTRL register bits.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLIP    = 1;
  localparam int CTRL_AUTO    = 2;
  localparam int CTRL_COL_LSB = 3;  // colour {R,G,B} in [5:3]

  typedef struct packed {
    logic [COORD_W_MAX-1:0]       x;
    logic [COORD_W_MAX-1:0]       y;
    logic [7:0]                   dx;
    logic [7:0]                   dy;
    logic [7:0]                   ctrl;
    logic [ROWS_MAX-1:0][7:0]     bitmap;
  } sprite_state_t;

  // Two's-complement negate that maps -128 to +127 instead of back to -128.
  function automatic logic [7:0] neg_sat(input logic [7:0] v);
    return (v == 8'h80) ? 8'h7F : 8'(-v);
  endfunction

endpackage

// File: rtl/sprite_engine_unit.sv
// -----------------------------------------------------------------------------
// sprite_unit
//   One sprite: its register window on the CPU bus, the once-per-frame motion
//   step with edge bounce, and the combinational hit test for the current
//   pixel.
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   i_pixel_x/_y        current pixel coordinate
//   i_frame_start       one-cycle pulse, advances auto-move sprites
//   i_reg_we/addr/data  CPU register write
//   o_opaque            this sprite covers the current pixel with a set bit
//   o_colour            {R,G,B} colour of this sprite
// -----------------------------------------------------------------------------
module sprite_unit
  import sprite_pkg::*;
#(
  parameter int IDX      = 0,
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int COORD_W  = 11,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] i_pixel_x,
  input  logic [COORD_W-1:0] i_pixel_y,
  input  logic               i_frame_start,
  input  logic               i_reg_we,
  input  logic [7:0]         i_reg_addr,
  input  logic [7:0]         i_reg_data,
  output logic               o_opaque,
  output logic [2:0]         o_colour
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [7:0]             HI_MASK = 8'((1 << (COORD_W - 8)) - 1);
  localparam logic signed [CW1-1:0]  X_MAX   = CW1'(H_ACTIVE - SPRITE_W);
  localparam logic signed [CW1-1:0]  Y_MAX   = CW1'(V_ACTIVE - SPRITE_H);

  sprite_state_t r_state;
  sprite_state_t w_next;

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  assign w_x = r_state.x[COORD_W-1:0];
  assign w_y = r_state.y[COORD_W-1:0];

  // ---------------------------------------------------------------- write decode
  logic       w_sel;
  logic [3:0] w_ofs;
  logic       w_bmp_hit;
  assign w_ofs     = i_reg_addr[3:0];
  assign w_sel     = i_reg_we && (i_reg_addr[7:4] == 4'(IDX));
  // Bitmap rows sit at offsets 8..15; only the first SPRITE_H are mapped.
  assign w_bmp_hit = w_ofs[3] && (int'(w_ofs[2:0]) < SPRITE_H);

  // ---------------------------------------------------------------- motion
  // Signed at COORD_W+1 bits so a step past zero shows up as negative.
  logic signed [CW1-1:0] w_nx;
  logic signed [CW1-1:0] w_ny;
  assign w_nx = $signed({1'b0, w_x}) + CW1'($signed(r_state.dx));
  assign w_ny = $signed({1'b0, w_y}) + CW1'($signed(r_state.dy));

  always_comb begin
    // NOTE: every field starts from its held value, so no branch below can
    // leave w_next unassigned and infer a latch.
    w_next = r_state;

    if (i_frame_start && r_state.ctrl[CTRL_EN] && r_state.ctrl[CTRL_AUTO]) begin
      if (w_nx[CW1-1]) begin
        w_next.x  = '0;
        w_next.dx = neg_sat(r_state.dx);
      end else if (w_nx > X_MAX) begin
        w_next.x  = COORD_W_MAX'(X_MAX);
        w_next.dx = neg_sat(r_state.dx);
      end else begin
        w_next.x  = COORD_W_MAX'(w_nx[COORD_W-1:0]);
      end

      if (w_ny[CW1-1]) begin
        w_next.y  = '0;
        w_next.dy = neg_sat(r_state.dy);
      end else if (w_ny > Y_MAX) begin
        w_next.y  = COORD_W_MAX'(Y_MAX);
        w_next.dy = neg_sat(r_state.dy);
      end else begin
        w_next.y  = COORD_W_MAX'(w_ny[COORD_W-1:0]);
      end
    end

    // Applied after motion so a CPU write to a field beats the frame step,
    // while untouched fields keep their stepped value.
    if (w_sel) begin
      case (w_ofs)
        OFS_XLO:  w_next.x[7:0]             = i_reg_data;
        OFS_XHI:  w_next.x[COORD_W_MAX-1:8] = i_reg_data & HI_MASK;
        OFS_YLO:  w_next.y[7:0]             = i_reg_data;
        OFS_YHI:  w_next.y[COORD_W_MAX-1:8] = i_reg_data & HI_MASK;
        OFS_DX:   w_next.dx                 = i_reg_data;
        OFS_DY:   w_next.dy                 = i_reg_data;
        OFS_CTRL: w_next.ctrl               = i_reg_data;
        default: begin
          if (w_bmp_hit) w_next.bitmap[w_ofs[2:0]] = i_reg_data;
        end
      endcase
    end
  end

  // NOTE: the bitmap is held in flops rather than a RAM so that reset clears
  // it together with the position and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= '0;
    // NOTE: non-blocking so every flop samples pre-edge values.
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------- hit test
  // One extra bit on both sides so X+SPRITE_W near the top of the range
  // cannot wrap back into the visible area.
  logic [CW1-1:0] w_px;
  logic [CW1-1:0] w_py;
  logic [CW1-1:0] w_x_ext;
  logic [CW1-1:0] w_y_ext;
  logic           w_in_box;
  logic [2:0]     w_col;
  logic [2:0]     w_row;
  logic [2:0]     w_bit;

  assign w_px    = {1'b0, i_pixel_x};
  assign w_py    = {1'b0, i_pixel_y};
  assign w_x_ext = {1'b0, w_x};
  assign w_y_ext = {1'b0, w_y};

  assign w_in_box = (w_px >= w_x_ext) && (w_px < w_x_ext + CW1'(SPRITE_W)) &&
                    (w_py >= w_y_ext) && (w_py < w_y_ext + CW1'(SPRITE_H));

  assign w_col = 3'(i_pixel_x - w_x);
  assign w_row = 3'(i_pixel_y - w_y);
  // Bit 7 is the leftmost pixel; flipping maps column c to 7-(SPRITE_W-1-c).
  assign w_bit = r_state.ctrl[CTRL_FLIP] ? (w_col + 3'(8 - SPRITE_W))
                                         : (3'd7 - w_col);

  assign o_opaque = r_state.ctrl[CTRL_EN] && w_in_box && r_state.bitmap[w_row][w_bit];
  assign o_colour = r_state.ctrl[CTRL_COL_LSB +: 3];

  // Upper coordinate bits and CTRL[7:6] are stored but never used.
  logic w_unused;
  assign w_unused = ^{r_state.x, r_state.y, r_state.ctrl};

endmodule

// File: rtl/sprite_engine.sv
// -----------------------------------------------------------------------------
// sprite_engine
//   Overlays NUM_SPRITES monochrome bitmap sprites on the VGA pixel stream.
//   The lowest-index opaque sprite supplies the colour; two or more opaque
//   sprites on a visible pixel latch the sticky COLLISION flag, which any
//   write to ADDR_COLL_CLR clears. RGB and COLLISION are registered, one
//   cycle behind PIXEL_X/PIXEL_Y/ON_SCREEN.
// Ports:
//   CLK_PIXEL, RESET_N            pixel clock, async active-low reset
//   PIXEL_X, PIXEL_Y, ON_SCREEN   current pixel from the timing generator
//   FRAME_START                   one-cycle pulse, steps auto-move sprites
//   REG_WE, REG_ADDR, REG_DATA    CPU register write port
//   VGA_RED/GREEN/BLUE            registered colour outputs
//   COLLISION                     sticky sprite-sprite overlap flag
// -----------------------------------------------------------------------------
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 8,
  parameter int SPRITE_H    = 8,
  parameter int COORD_W     = 11,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600
) (
  input  logic               CLK_PIXEL,
  input  logic               RESET_N,
  input  logic [COORD_W-1:0] PIXEL_X,
  input  logic [COORD_W-1:0] PIXEL_Y,
  input  logic               ON_SCREEN,
  input  logic               FRAME_START,
  input  logic               REG_WE,
  input  logic [7:0]         REG_ADDR,
  input  logic [7:0]         REG_DATA,
  output logic               VGA_RED,
  output logic               VGA_GREEN,
  output logic               VGA_BLUE,
  output logic               COLLISION
);

  logic [NUM_SPRITES-1:0] w_opaque;
  logic [2:0]             w_colour [NUM_SPRITES];

  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_spr
    sprite_unit #(
      .IDX      (s),
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .COORD_W  (COORD_W),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
    ) u_unit (
      .clk           (CLK_PIXEL),
      .rst_n         (RESET_N),
      .i_pixel_x     (PIXEL_X),
      .i_pixel_y     (PIXEL_Y),
      .i_frame_start (FRAME_START),
      .i_reg_we      (REG_WE),
      .i_reg_addr    (REG_ADDR),
      .i_reg_data    (REG_DATA),
      .o_opaque      (w_opaque[s]),
      .o_colour      (w_colour[s])
    );
  end

  // ---------------------------------------------------------------- priority
  logic [2:0] w_win_colour;
  logic       w_any;
  logic       w_multi;
  logic       w_coll_clr;

  always_comb begin
    logic seen;
    w_win_colour = 3'b000;
    w_multi      = 1'b0;
    seen         = 1'b0;
    // Walk from the top down so the lowest index is the last, winning write.
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (w_opaque[s]) w_win_colour = w_colour[s];
    end
    for (int s = 0; s < NUM_SPRITES; s++) begin
      if (w_opaque[s] && seen) w_multi = 1'b1;
      if (w_opaque[s])         seen    = 1'b1;
    end
  end

  assign w_any      = |w_opaque;
  assign w_coll_clr = REG_WE && (REG_ADDR == ADDR_COLL_CLR);

  // ---------------------------------------------------------------- outputs
  logic [2:0] r_rgb;
  logic       r_collision;

  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rgb       <= 3'b000;
      r_collision <= 1'b0;
    end else begin
      r_rgb <= (ON_SCREEN && w_any) ? w_win_colour : 3'b000;
      // A new overlap outranks a clear arriving in the same cycle.
      if (ON_SCREEN && w_multi) r_collision <= 1'b1;
      else if (w_coll_clr)      r_collision <= 1'b0;
    end
  end

  assign VGA_RED   = r_rgb[2];
  assign VGA_GREEN = r_rgb[1];
  assign VGA_BLUE  = r_rgb[0];
  assign COLLISION = r_collision;

endmodule

// File: tb/tb_sprite_engine.sv
// -----------------------------------------------------------------------------
// tb_sprite_engine
//   Self-checking bench for sprite_engine. A behavioural model of the sprites
//   (integer positions, per-row bitmaps, mirrored columns) predicts RGB and
//   COLLISION; a compare process checks the DUT against it on every falling
//   edge, and directed scenarios pin model and DUT to hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_engine;

  localparam int NS = 4;
  localparam int SW = 8;
  localparam int SH = 8;
  localparam int CW = 11;
  localparam int HA = 800;
  localparam int VA = 600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] px = '0;
  logic [CW-1:0] py = '0;
  logic          on_scr = 1'b0;
  logic          frame_start = 1'b0;
  logic          reg_we = 1'b0;
  logic [7:0]    reg_addr = '0;
  logic [7:0]    reg_data = '0;
  logic          vga_r, vga_g, vga_b, coll;

  sprite_engine #(
    .NUM_SPRITES (NS), .SPRITE_W (SW), .SPRITE_H (SH),
    .COORD_W (CW), .H_ACTIVE (HA), .V_ACTIVE (VA)
  ) dut (
    .CLK_PIXEL   (clk),
    .RESET_N     (rst_n),
    .PIXEL_X     (px),
    .PIXEL_Y     (py),
    .ON_SCREEN   (on_scr),
    .FRAME_START (frame_start),
    .REG_WE      (reg_we),
    .REG_ADDR    (reg_addr),
    .REG_DATA    (reg_data),
    .VGA_RED     (vga_r),
    .VGA_GREEN   (vga_g),
    .VGA_BLUE    (vga_b),
    .COLLISION   (coll)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name,
                  $signed(act), $signed(exp), $time);
  endtask

  // ---------------------------------------------------------------- model
  int       m_x [NS];
  int       m_y [NS];
  int       m_dx[NS];
  int       m_dy[NS];
  bit       m_en[NS];
  bit       m_flip[NS];
  bit       m_auto[NS];
  int       m_col[NS];
  bit [7:0] m_bmp[NS][SH];
  logic [2:0] exp_rgb  = 3'b000;
  logic       exp_coll = 1'b0;

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      m_x[s] = 0; m_y[s] = 0; m_dx[s] = 0; m_dy[s] = 0;
      m_en[s] = 0; m_flip[s] = 0; m_auto[s] = 0; m_col[s] = 0;
      for (int r = 0; r < SH; r++) m_bmp[s][r] = 8'h00;
    end
    exp_rgb  = 3'b000;
    exp_coll = 1'b0;
  endtask

  function automatic int neg_sat(input int v);
    return (v == -128) ? 127 : -v;
  endfunction

  function automatic bit m_opaque(input int s, input int x, input int y);
    int col, row;
    if (!m_en[s]) return 1'b0;
    if (x < m_x[s] || x >= m_x[s] + SW || y < m_y[s] || y >= m_y[s] + SH) return 1'b0;
    col = x - m_x[s];
    row = y - m_y[s];
    if (m_flip[s]) col = SW - 1 - col;   // mirror within the sprite box
    return m_bmp[s][row][7 - col];
  endfunction

  task automatic m_axis(inout int p, inout int v, input int lim);
    int n = p + v;
    if (n < 0)        begin p = 0;   v = neg_sat(v); end
    else if (n > lim) begin p = lim; v = neg_sat(v); end
    else              p = n;
  endtask

  task automatic m_frame();
    for (int s = 0; s < NS; s++) begin
      int p, v;
      if (m_en[s] && m_auto[s]) begin
        p = m_x[s]; v = m_dx[s]; m_axis(p, v, HA - SW); m_x[s] = p; m_dx[s] = v;
        p = m_y[s]; v = m_dy[s]; m_axis(p, v, VA - SH); m_y[s] = p; m_dy[s] = v;
      end
    end
  endtask

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    int s = int'(a[7:4]);
    int o = int'(a[3:0]);
    int hi = int'(d) & ((1 << (CW - 8)) - 1);
    if (s >= NS) return;
    case (o)
      0: m_x[s]  = (m_x[s] & ~255) | int'(d);
      1: m_x[s]  = (m_x[s] & 255) | (hi << 8);
      2: m_y[s]  = (m_y[s] & ~255) | int'(d);
      3: m_y[s]  = (m_y[s] & 255) | (hi << 8);
      4: m_dx[s] = int'($signed(d));
      5: m_dy[s] = int'($signed(d));
      6: begin
        m_en[s] = d[0]; m_flip[s] = d[1]; m_auto[s] = d[2]; m_col[s] = int'(d[5:3]);
      end
      default: if (o >= 8 && o < 8 + SH) m_bmp[s][o - 8] = d;
    endcase
  endtask

  task automatic m_edge();
    int win = -1;
    int cnt = 0;
    for (int s = 0; s < NS; s++) begin
      if (m_opaque(s, int'(px), int'(py))) begin
        cnt++;
        if (win < 0) win = s;
      end
    end
    exp_rgb = 3'b000;
    if (on_scr && win >= 0) exp_rgb = 3'(m_col[win]);
    if (on_scr && cnt >= 2) exp_coll = 1'b1;
    else if (reg_we && reg_addr == 8'hF0) exp_coll = 1'b0;
    if (frame_start) m_frame();
    if (reg_we) m_write(reg_addr, reg_data);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_edge();
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("rgb_vs_model", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
      check("coll_vs_model", 32'(coll), 32'(exp_coll));
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_data = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input bit on);
    px = CW'(x); py = CW'(y); on_scr = on;
    @(negedge clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  function automatic logic [31:0] rgb();
    return 32'({vga_r, vga_g, vga_b});
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    m_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rgb", rgb(), 0);
    check("rst_coll", 32'(coll), 0);
    check("rst_x0", 32'(dut.g_spr[0].u_unit.r_state.x), 0);
    check("rst_ctrl3", 32'(dut.g_spr[NS-1].u_unit.r_state.ctrl), 0);
    check("rst_bmp3", 32'(|dut.g_spr[NS-1].u_unit.r_state.bitmap), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Sweep with everything disabled: nothing may light.
    frame();
    for (int x = 0; x < HA; x++) begin
      pix(x, int'($urandom_range(0, VA - 1)), 1'b1);
      check("sweep_dark", {rgb()[30:0], coll}, 0);
    end

    // Sprite 0 at (20,40), leftmost pixel of row 0, red
    wr(8'h00, 8'd20); wr(8'h01, 8'd0); wr(8'h02, 8'd40); wr(8'h03, 8'd0);
    wr(8'h08, 8'h80); wr(8'h06, 8'h21);
    pix(20, 40, 1'b1);  check("t2_lit", 32'(vga_r), 1);
    pix(21, 40, 1'b1);  check("t2_next_dark", 32'(vga_r), 0);
    pix(20, 40, 1'b0);  check("t2_offscreen", rgb(), 0);
    wr(8'h06, 8'h23);   // flip_h
    pix(27, 40, 1'b1);  check("t2_flip_lit", 32'(vga_r), 1);
    pix(20, 40, 1'b1);  check("t2_flip_dark", 32'(vga_r), 0);

    // Sprite 0 red over sprite 1 blue, full rows
    wr(8'h06, 8'h21); wr(8'h08, 8'hFF);
    wr(8'h10, 8'd20); wr(8'h12, 8'd40); wr(8'h18, 8'hFF); wr(8'h16, 8'h09);
    pix(22, 40, 1'b1);  check("t3_priority", rgb(), 3'b100);
                        check("t3_coll_set", 32'(coll), 1);
    pix(0, 500, 1'b1);
    wr(8'hF0, 8'h00);   check("t3_coll_clr", 32'(coll), 0);
    pix(0, 500, 1'b1);  check("t3_coll_stays_clr", 32'(coll), 0);
    px = CW'(23); py = CW'(40); on_scr = 1'b1;
    wr(8'hF0, 8'h00);   check("t3_set_beats_clr", 32'(coll), 1);
    wr(8'h06, 8'h00); wr(8'h16, 8'h00);
    pix(0, 500, 1'b1);  wr(8'hF0, 8'h00);

    // Sprite 2: right-edge bounce
    wr(8'h20, 8'h16); wr(8'h21, 8'h03);          // X = 790
    wr(8'h22, 8'd100); wr(8'h24, 8'd5); wr(8'h28, 8'h80); wr(8'h26, 8'h15);
    frame();
    check("t4_model_x", 32'(m_x[2]), 792);
    check("t4_model_dx", 32'(m_dx[2]), 32'(-5));
    pix(792, 100, 1'b1); check("t4_x792", rgb(), 3'b010);
    pix(790, 100, 1'b1); check("t4_x790_dark", rgb(), 0);
    frame();
    check("t4_model_x2", 32'(m_x[2]), 787);
    pix(787, 100, 1'b1); check("t4_x787", rgb(), 3'b010);
    wr(8'h26, 8'h00);

    // Sprite 3: top-edge bounce, then DX = -128 saturation
    wr(8'h30, 8'd100); wr(8'h31, 8'd0); wr(8'h32, 8'd2); wr(8'h33, 8'd0);
    wr(8'h34, 8'h00); wr(8'h35, 8'hFD); wr(8'h38, 8'h80); wr(8'h36, 8'h3D);
    frame();
    check("t5_model_y", 32'(m_y[3]), 0);
    check("t5_model_dy", 32'(m_dy[3]), 3);
    pix(100, 0, 1'b1);   check("t5_y0", rgb(), 3'b111);
    wr(8'h35, 8'h00); wr(8'h30, 8'd50); wr(8'h34, 8'h80);
    frame();
    check("t5_model_dx_sat", 32'(m_dx[3]), 127);
    pix(0, 0, 1'b1);     check("t5_x0", rgb(), 3'b111);
    frame();
    pix(127, 0, 1'b1);   check("t5_x127", rgb(), 3'b111);
    pix(126, 0, 1'b1);   check("t5_x126_dark", rgb(), 0);

    // CPU write to X on the frame-step cycle wins; Y still steps
    wr(8'h35, 8'd4);
    reg_we = 1'b1; reg_addr = 8'h30; reg_data = 8'd200; frame_start = 1'b1;
    @(negedge clk);
    reg_we = 1'b0; frame_start = 1'b0;
    check("t6_model_x", 32'(m_x[3]), 200);
    check("t6_model_y", 32'(m_y[3]), 4);
    pix(200, 4, 1'b1);   check("t6_write_wins", rgb(), 3'b111);
    pix(254, 4, 1'b1);   check("t6_no_step_x", rgb(), 0);

    // Reset mid-line: outputs drop without a clock edge
    pix(200, 4, 1'b1);   check("t6_prelit", rgb(), 3'b111);
    #2 rst_n = 1'b0;
    #1 check("t6_async_rgb", rgb(), 0);
    check("t6_rst_ctrl3", 32'(dut.g_spr[3].u_unit.r_state.ctrl), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model
    for (int s = 0; s < NS; s++) begin
      wr(8'(s * 16 + 0), 8'($urandom_range(0, 255)));
      wr(8'(s * 16 + 2), 8'($urandom_range(0, 255)));
      wr(8'(s * 16 + 4), 8'($urandom_range(0, 255)));
      wr(8'(s * 16 + 5), 8'($urandom_range(0, 255)));
      for (int r = 0; r < SH; r++) wr(8'(s * 16 + 8 + r), 8'($urandom));
      wr(8'(s * 16 + 6), 8'($urandom_range(0, 63)) | 8'h05);
    end
    for (int i = 0; i < 4000; i++) begin
      int s  = int'($urandom_range(0, NS - 1));
      int r  = int'($urandom_range(0, 99));
      int xx = m_x[s] + int'($urandom_range(0, 11)) - 2;
      int yy = m_y[s] + int'($urandom_range(0, 11)) - 2;
      int o  = int'($urandom_range(0, 15));
      px = CW'((xx < 0) ? 0 : xx);
      py = CW'((yy < 0) ? 0 : yy);
      on_scr = ($urandom_range(0, 7) != 0);
      frame_start = (r < 2);
      reg_we = (r >= 2 && r < 14);
      if ($urandom_range(0, 11) == 0) reg_addr = 8'hF0;
      else reg_addr = 8'(int'($urandom_range(0, 5)) * 16 + o);
      if (o == 1 || o == 3) reg_data = 8'($urandom_range(0, 2));
      else                  reg_data = 8'($urandom);
      @(negedge clk);
    end
    frame_start = 1'b0;
    reg_we = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
